// File: rtl/anton_pkg.sv
`default_nettype none
// anton_pkg: shared FSM state type and datapath widths for the anton_driver slice.
package anton_pkg;

  localparam int NIBBLE_W = 4;
  localparam int RESULT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_shifter.sv
`default_nettype none
// nibble_shifter: parallel-load register that exposes its most-significant nibble
// and shifts left one nibble per enabled cycle.
module nibble_shifter
  import anton_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         shift,
  input  logic [NIBBLES*NIBBLE_W-1:0]  load_data,
  output logic [NIBBLE_W-1:0]          msn
);

  localparam int WIDTH = NIBBLES * NIBBLE_W;

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      // A plain shift stays legal when NIBBLES == 1, unlike a part-select concat
      sr <= sr << NIBBLE_W;
    end
  end

  assign msn = sr[WIDTH-1 -: NIBBLE_W];

endmodule
`default_nettype wire

// File: rtl/anton_driver.sv
`default_nettype none
// anton_driver: shifts an operand to a nibble-serial device MSN-first, waits for it
// to settle, captures its result byte and hands it to the host over valid/ready.
module anton_driver
  import anton_pkg::*;
#(
  parameter int NIBBLES       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [NIBBLES*NIBBLE_W-1:0]  cmd_data,
  output logic [NIBBLE_W-1:0]          dev_nibble,
  output logic                         dev_read,
  input  logic [RESULT_W-1:0]          dev_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [RESULT_W-1:0]          rsp_data
);

  localparam int MAX_CNT = (NIBBLES > SETTLE_CYCLES) ? NIBBLES : SETTLE_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] SHIFT_LOAD  = CNT_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt, next_cnt;
  logic                 accept;
  logic                 shift_en;
  logic                 capture;
  logic [NIBBLE_W-1:0]  msn;

  nibble_shifter #(
    .NIBBLES (NIBBLES)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .shift     (shift_en),
    .load_data (cmd_data),
    .msn       (msn)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rsp_data <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (capture) begin
        rsp_data <= dev_result;
      end
    end
  end

  // The counter counts down to zero and is reloaded whenever a timed state is entered
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    cmd_ready  = 1'b0;
    dev_nibble = '0;
    dev_read   = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    shift_en   = 1'b0;
    capture    = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          next_state = SHIFT;
          next_cnt   = SHIFT_LOAD;
        end
      end
      SHIFT: begin
        dev_nibble = msn;
        shift_en   = 1'b1;
        if (cnt == '0) begin
          next_state = SETTLE;
          next_cnt   = SETTLE_LOAD;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      SETTLE: begin
        dev_read = 1'b1;
        if (cnt == '0) begin
          capture    = 1'b1;
          next_state = RESP;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_anton_driver.sv
`default_nettype none
// tb_anton_driver: directed self-checking bench for the default build and a
// NIBBLES=1 / SETTLE_CYCLES=1 build of anton_driver.
module tb_anton_driver;

  logic        clk = 1'b0;
  logic        reset;

  logic        cmd_valid, cmd_ready, dev_read, rsp_valid, rsp_ready;
  logic [15:0] cmd_data;
  logic [3:0]  dev_nibble;
  logic [7:0]  dev_result, rsp_data;

  logic        c1_valid, c1_ready, c1_read, c1_rsp_valid, c1_rsp_ready;
  logic [3:0]  c1_data, c1_nibble;
  logic [7:0]  c1_result, c1_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Device models: present a fixed result only while asked to read
  assign dev_result = dev_read ? 8'hE7 : 8'h00;
  assign c1_result  = c1_read  ? 8'h3C : 8'h00;

  anton_driver #(.NIBBLES(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .dev_nibble(dev_nibble), .dev_read(dev_read), .dev_result(dev_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  anton_driver #(.NIBBLES(1), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_data(c1_data),
    .dev_nibble(c1_nibble), .dev_read(c1_read), .dev_result(c1_result),
    .rsp_valid(c1_rsp_valid), .rsp_ready(c1_rsp_ready), .rsp_data(c1_rsp_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in cycle T+1 after acceptance; leaves the bench in cycle T+7 (RESP)
  task automatic run_txn(input logic [15:0] word, input bit pulse_busy);
    logic [3:0] exp_nib;
    for (int i = 0; i < 4; i++) begin
      exp_nib = word[15 - 4*i -: 4];
      check($sformatf("nibble%0d", i), dev_nibble, exp_nib);
      check($sformatf("shift_read%0d", i), dev_read, 1'b0);
      check($sformatf("shift_ready%0d", i), cmd_ready, 1'b0);
      if (pulse_busy && i == 1) begin
        cmd_valid = 1'b1;
        cmd_data  = 16'hFFFF;
      end else if (pulse_busy && i == 2) begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("settle_read%0d", i), dev_read, 1'b1);
      check($sformatf("settle_nibble%0d", i), dev_nibble, 4'h0);
      check($sformatf("settle_rsp%0d", i), rsp_valid, 1'b0);
      tick();
    end
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_data", rsp_data, 8'hE7);
    check("rsp_read", dev_read, 1'b0);
  endtask

  initial begin
    bit seen_rsp;
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
    c1_valid = 1'b0; c1_data = '0; c1_rsp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_dev_nibble", dev_nibble, 4'h0);
    check("rst_dev_read", dev_read, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    tick();

    // Basic transaction followed by 10 cycles of response backpressure
    cmd_valid = 1'b1; cmd_data = 16'h3A5C;
    tick();
    cmd_valid = 1'b0;
    run_txn(16'h3A5C, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_data", rsp_data, 8'hE7);
      check("bp_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle_ready", cmd_ready, 1'b1);
    check("bp_idle_valid", rsp_valid, 1'b0);

    // Busy: a command pulsed during SHIFT must not disturb the stream
    cmd_valid = 1'b1; cmd_data = 16'h3A5C;
    tick();
    cmd_valid = 1'b0;
    run_txn(16'h3A5C, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("busy_idle_ready", cmd_ready, 1'b1);
    tick();
    check("busy_no_accept", cmd_ready, 1'b1);

    // Reset mid-SETTLE, with a command offered in the reset cycle
    cmd_valid = 1'b1; cmd_data = 16'h3A5C;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_reset_read", dev_read, 1'b1);
    reset = 1'b1; cmd_valid = 1'b1;
    tick();
    reset = 1'b0; cmd_valid = 1'b0;
    check("mid_rst_read", dev_read, 1'b0);
    check("mid_rst_rsp", rsp_valid, 1'b0);
    check("mid_rst_ready", cmd_ready, 1'b1);
    check("mid_rst_nibble", dev_nibble, 4'h0);
    seen_rsp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) seen_rsp = 1'b1;
    end
    check("mid_rst_no_rsp", seen_rsp, 1'b0);
    check("mid_rst_still_idle", cmd_ready, 1'b1);

    // Back-to-back with cmd_valid and rsp_ready held high
    cmd_valid = 1'b1; rsp_ready = 1'b1; cmd_data = 16'h0001;
    tick();
    cmd_data = 16'h8000;
    run_txn(16'h0001, 1'b0);
    check("b2b_rsp1_ready", cmd_ready, 1'b0);
    tick();
    check("b2b_gap_ready", cmd_ready, 1'b1);
    check("b2b_gap_valid", rsp_valid, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("b2b_second_busy", cmd_ready, 1'b0);
    run_txn(16'h8000, 1'b0);
    tick();
    rsp_ready = 1'b0;
    check("b2b_end_ready", cmd_ready, 1'b1);
    check("b2b_end_valid", rsp_valid, 1'b0);

    // Minimal parameterisation
    check("p1_idle_ready", c1_ready, 1'b1);
    c1_valid = 1'b1; c1_data = 4'h9;
    tick();
    c1_valid = 1'b0;
    check("p1_nibble", c1_nibble, 4'h9);
    check("p1_shift_read", c1_read, 1'b0);
    tick();
    check("p1_settle_read", c1_read, 1'b1);
    check("p1_settle_nibble", c1_nibble, 4'h0);
    check("p1_settle_rsp", c1_rsp_valid, 1'b0);
    tick();
    check("p1_rsp_valid", c1_rsp_valid, 1'b1);
    check("p1_rsp_data", c1_rsp_data, 8'h3C);
    check("p1_rsp_read", c1_read, 1'b0);
    c1_rsp_ready = 1'b1;
    tick();
    c1_rsp_ready = 1'b0;
    check("p1_back_idle", c1_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/anton_driver.md
ANTON_DRIVER -- requirements
Module: anton_driver

Interface
REQ-001 The module SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles shifted to the device per transaction (range 1..8).
REQ-002 The module SHALL have parameter SETTLE_CYCLES, default 2, giving the number of cycles dev_read is held high before capture (minimum 1).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  host offers an operand word.
REQ-006 cmd_ready  output  1  driver can accept an operand word.
REQ-007 cmd_data  input  4*NIBBLES  operand word, most-significant nibble sent first.
REQ-008 dev_nibble  output  4  nibble presented to the device.
REQ-009 dev_read  output  1  high = device asked to present its result; low = nibble load phase.
REQ-010 dev_result  input  8  result byte from the device.
REQ-011 rsp_valid  output  1  captured result available.
REQ-012 rsp_ready  input  1  host accepts the result.
REQ-013 rsp_data  output  8  captured result byte.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT, SETTLE and RESP.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-016 On acceptance, cmd_data SHALL be latched into a shift register and the FSM SHALL move to SHIFT.
REQ-017 In SHIFT, dev_nibble SHALL present latched nibbles MSN-first, one per cycle, for exactly NIBBLES cycles, with dev_read=0.
REQ-018 After the last nibble the FSM SHALL enter SETTLE: dev_read=1 for exactly SETTLE_CYCLES cycles, with dev_nibble=0.
REQ-019 On the final SETTLE edge, dev_result SHALL be registered into rsp_data and the FSM SHALL enter RESP.
REQ-020 In RESP, rsp_valid SHALL be 1 with dev_read=0.
REQ-021 rsp_data SHALL stay stable until the handshake (rsp_valid & rsp_ready) completes; the FSM then returns to IDLE.
REQ-022 Latency: command accepted at edge T -> nibbles on cycles T+1..T+NIBBLES -> dev_read high for the next SETTLE_CYCLES cycles -> rsp_valid first high in cycle T+NIBBLES+SETTLE_CYCLES+1.
REQ-023 No overlap: cmd_ready SHALL rise no earlier than the cycle after the response handshake, even if rsp_ready is held high.
REQ-024 cmd_valid outside IDLE SHALL be ignored, with no state change.
REQ-025 In IDLE, dev_nibble=0 and dev_read=0.
REQ-026 A single cycle counter, sized for max(NIBBLES, SETTLE_CYCLES), SHALL time both SHIFT and SETTLE, reloading on every state entry.

Reset
REQ-027 While reset=1 at an edge, the FSM SHALL go to IDLE and the outputs SHALL take: cmd_ready=1, dev_nibble=0, dev_read=0, rsp_valid=0, rsp_data=0.
REQ-028 Reset asserted mid-transaction (any state) SHALL abandon the transaction with no response.
REQ-029 A cmd_valid presented in the same cycle as reset SHALL NOT be accepted.

Structure
REQ-030 A shared package anton_pkg SHALL hold the FSM state type, the nibble width constant (4) and the result width constant (8).
REQ-031 One sub-module, nibble_shifter, SHALL hold the parallel-load, MSN-first 4-bit shift register; everything else stays in anton_driver.

Verification
REQ-032 Basic: NIBBLES=4, SETTLE_CYCLES=2, cmd_data=16'h3A5C, device model returns 8'hE7 while dev_read=1 -> dev_nibble 3,A,5,C on T+1..T+4; dev_read high T+5..T+6; rsp_valid=1 with rsp_data=8'hE7 at T+7.
REQ-033 Backpressure: rsp_ready held low 10 cycles after rsp_valid -> rsp_data holds 8'hE7; cmd_ready=0 throughout; IDLE one cycle after rsp_ready=1.
REQ-034 Busy ignore: second cmd_valid with 16'hFFFF pulsed during SHIFT -> not accepted; dev_nibble sequence unchanged.
REQ-035 Reset mid-SETTLE: reset pulsed on T+5 -> next cycle dev_read=0, rsp_valid=0, cmd_ready=1; no response is ever issued.
REQ-036 Back-to-back: cmd_valid and rsp_ready held high, operands 16'h0001 then 16'h8000 -> two responses; exactly one IDLE cycle between them; second nibble stream is 8,0,0,0.
REQ-037 Parameter sweep: NIBBLES=1, SETTLE_CYCLES=1, cmd_data=4'h9 -> one nibble 9 on T+1, dev_read high on T+2, rsp_valid at T+3.
